// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the program counter.
//   pc_src_t      : PC mux select encoding (shared with the PC register mux)
//   fetch_state_t : fetch sequencer FSM states
//   MAX_WAIT_DEFAULT : default fetch-timeout threshold in cycles
package cpu_pkg;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_UNCOND = 2'b01,
      PC_COND   = 2'b10,
      PC_REG    = 2'b11
   } pc_src_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } fetch_state_t;

   localparam int unsigned MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: drives the PC write enable / source select, runs the
// request/ready handshake with a variable-latency instruction memory, buffers a
// fetched word across load-use stalls and squashes wrong-path fetches on
// branch redirects.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   stall               : load-use stall from the hazard unit
//   redirect_valid/kind : taken branch resolved in ID and its PC source
//   imem_ready/rdata    : instruction memory response
//   imem_req            : fetch request (PC stable while high and not ready)
//   pc_en, pc_src       : PC write enable and mux select
//   if_valid, if_instr  : instruction toward IF/ID
//   if_id_flush         : write a bubble into IF/ID
//   id_hold             : ID must hold branch operands (redirect pending)
//   timeout_err         : sticky, a fetch waited MAX_WAIT cycles
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [1:0]  redirect_kind,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic        pc_en,
   output logic [1:0]  pc_src,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic        if_id_flush,
   output logic        id_hold,
   output logic        timeout_err
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   fetch_state_t state_q, state_d;
   logic [31:0]  buf_q, buf_d;
   logic [7:0]   wait_cnt_q, wait_cnt_d;
   logic         timeout_q, timeout_d;

   logic         redirect;
   pc_src_t      pc_src_e;

   // kind 00 is illegal and must behave as if no redirect were present
   assign redirect = redirect_valid && (redirect_kind != 2'b00);

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      imem_req    = 1'b0;
      pc_en       = 1'b0;
      pc_src_e    = PC_SEQ;
      if_valid    = 1'b0;
      if_instr    = '0;
      if_id_flush = 1'b0;
      id_hold     = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if_instr = imem_rdata;
            if (!imem_ready) begin
               // PC must stay put; a redirect waits for the ready cycle
               id_hold = redirect;
            end else if (redirect) begin
               pc_en       = 1'b1;
               pc_src_e    = pc_src_t'(redirect_kind);
               if_id_flush = 1'b1;
            end else if (stall) begin
               buf_d   = imem_rdata;
               state_d = HOLD;
            end else begin
               pc_en    = 1'b1;
               if_valid = 1'b1;
            end
         end
         HOLD: begin
            if_instr = buf_q;
            if (redirect) begin
               pc_en       = 1'b1;
               pc_src_e    = pc_src_t'(redirect_kind);
               if_id_flush = 1'b1;
               state_d     = FETCH;
            end else if (!stall) begin
               if_valid = 1'b1;
               pc_en    = 1'b1;
               state_d  = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Wait counter saturates at the limit; the error flag latches on the edge
   // where the counter first reaches it and stays until reset.
   always_comb begin
      wait_cnt_d = '0;
      timeout_d  = timeout_q;
      if (state_q == FETCH && !imem_ready) begin
         if (wait_cnt_q == WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q;
         end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
         if (wait_cnt_d == WAIT_LIMIT) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign pc_src      = pc_src_e;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (MAX_WAIT overridden to 4).
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [1:0]  redirect_kind;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_req;
   logic        pc_en;
   logic [1:0]  pc_src;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        if_id_flush;
   logic        id_hold;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   fetch_sequencer #(.MAX_WAIT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_kind  (redirect_kind),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .imem_req       (imem_req),
      .pc_en          (pc_en),
      .pc_src         (pc_src),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_id_flush    (if_id_flush),
      .id_hold        (id_hold),
      .timeout_err    (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // settle combinational outputs after input changes
   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_kind = 2'b00;
      imem_ready = 1'b0; imem_rdata = '0;

      // reset held for 2 cycles
      tick(); tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);

      // reset falls; still IDLE this cycle
      reset = 1'b0;
      imem_ready = 1'b1; imem_rdata = 32'h91000421;
      settle();
      chk("idle_req", 32'(imem_req), 32'd0);
      chk("idle_valid", 32'(if_valid), 32'd0);
      tick();

      // streaming, zero-wait memory
      chk("s0_req", 32'(imem_req), 32'd1);
      chk("s0_pc_en", 32'(pc_en), 32'd1);
      chk("s0_pc_src", 32'(pc_src), 32'd0);
      chk("s0_valid", 32'(if_valid), 32'd1);
      chk("s0_instr", if_instr, 32'h91000421);
      tick();
      imem_rdata = 32'h91000842;
      settle();
      chk("s1_pc_en", 32'(pc_en), 32'd1);
      chk("s1_valid", 32'(if_valid), 32'd1);
      chk("s1_instr", if_instr, 32'h91000842);
      tick();

      // variable latency: 3 wait cycles then data
      imem_ready = 1'b0; imem_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("lat_req", 32'(imem_req), 32'd1);
         chk("lat_pc_en", 32'(pc_en), 32'd0);
         chk("lat_valid", 32'(if_valid), 32'd0);
         tick();
      end
      chk("lat_no_timeout", 32'(timeout_err), 32'd0);
      imem_ready = 1'b1; imem_rdata = 32'hAAAA5555;
      settle();
      chk("lat_valid_rdy", 32'(if_valid), 32'd1);
      chk("lat_instr", if_instr, 32'hAAAA5555);
      chk("lat_pc_en_rdy", 32'(pc_en), 32'd1);
      tick();

      // stall buffering
      imem_rdata = 32'h12345678; stall = 1'b1;
      settle();
      chk("st_cap_pc_en", 32'(pc_en), 32'd0);
      chk("st_cap_valid", 32'(if_valid), 32'd0);
      tick();
      imem_rdata = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("hold_req", 32'(imem_req), 32'd0);
         chk("hold_pc_en", 32'(pc_en), 32'd0);
         chk("hold_valid", 32'(if_valid), 32'd0);
         chk("hold_instr", if_instr, 32'h12345678);
         tick();
      end
      stall = 1'b0;
      settle();
      chk("rel_valid", 32'(if_valid), 32'd1);
      chk("rel_instr", if_instr, 32'h12345678);
      chk("rel_pc_en", 32'(pc_en), 32'd1);
      chk("rel_pc_src", 32'(pc_src), 32'd0);
      tick();

      // redirect with memory ready
      chk("back_fetch_req", 32'(imem_req), 32'd1);
      redirect_valid = 1'b1; redirect_kind = 2'b11; imem_rdata = 32'h11111111;
      settle();
      chk("rd_pc_src", 32'(pc_src), 32'd3);
      chk("rd_pc_en", 32'(pc_en), 32'd1);
      chk("rd_flush", 32'(if_id_flush), 32'd1);
      chk("rd_valid", 32'(if_valid), 32'd0);
      tick();

      // redirect behind an outstanding fetch
      imem_ready = 1'b0; redirect_kind = 2'b01;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("out_id_hold", 32'(id_hold), 32'd1);
         chk("out_pc_en", 32'(pc_en), 32'd0);
         chk("out_flush", 32'(if_id_flush), 32'd0);
         tick();
      end
      imem_ready = 1'b1;
      settle();
      chk("out_pc_src", 32'(pc_src), 32'd1);
      chk("out_pc_en_rdy", 32'(pc_en), 32'd1);
      chk("out_flush_rdy", 32'(if_id_flush), 32'd1);
      chk("out_id_hold_rdy", 32'(id_hold), 32'd0);
      tick();

      // redirect during HOLD (also beats stall)
      redirect_valid = 1'b0; redirect_kind = 2'b00;
      stall = 1'b1; imem_rdata = 32'h0BADF00D;
      tick();
      redirect_valid = 1'b1; redirect_kind = 2'b10;
      settle();
      chk("hr_req", 32'(imem_req), 32'd0);
      chk("hr_pc_src", 32'(pc_src), 32'd2);
      chk("hr_pc_en", 32'(pc_en), 32'd1);
      chk("hr_flush", 32'(if_id_flush), 32'd1);
      chk("hr_valid", 32'(if_valid), 32'd0);
      tick();
      redirect_valid = 1'b0; redirect_kind = 2'b00; stall = 1'b0;
      imem_rdata = 32'h22222222;
      settle();
      chk("hr_back_req", 32'(imem_req), 32'd1);
      chk("hr_back_instr", if_instr, 32'h22222222);
      tick();

      // illegal redirect kind 00 is ignored
      redirect_valid = 1'b1; redirect_kind = 2'b00;
      imem_ready = 1'b0;
      settle();
      chk("k00_id_hold", 32'(id_hold), 32'd0);
      tick();
      imem_ready = 1'b1; imem_rdata = 32'h33333333;
      settle();
      chk("k00_valid", 32'(if_valid), 32'd1);
      chk("k00_pc_src", 32'(pc_src), 32'd0);
      chk("k00_flush", 32'(if_id_flush), 32'd0);
      chk("k00_instr", if_instr, 32'h33333333);
      tick();
      redirect_valid = 1'b0;

      // timeout at the 4th wait edge, sticky afterwards
      imem_ready = 1'b0;
      settle();
      chk("to_before", 32'(timeout_err), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("to_edge%0d", k), 32'(timeout_err), (k >= 4) ? 32'd1 : 32'd0);
         chk("to_pc_en", 32'(pc_en), 32'd0);
      end
      imem_ready = 1'b1; imem_rdata = 32'h44444444;
      settle();
      chk("to_resume_valid", 32'(if_valid), 32'd1);
      tick();
      chk("to_sticky", 32'(timeout_err), 32'd1);

      // asynchronous reset in the middle of a wait
      imem_ready = 1'b0; redirect_valid = 1'b1; redirect_kind = 2'b01;
      settle();
      chk("ar_pre_hold", 32'(id_hold), 32'd1);
      chk("ar_pre_req", 32'(imem_req), 32'd1);
      reset = 1'b1;
      #1;
      chk("ar_req", 32'(imem_req), 32'd0);
      chk("ar_id_hold", 32'(id_hold), 32'd0);
      chk("ar_timeout", 32'(timeout_err), 32'd0);
      chk("ar_instr", if_instr, 32'd0);
      chk("ar_pc_src", 32'(pc_src), 32'd0);
      tick();
      reset = 1'b0; redirect_valid = 1'b0; redirect_kind = 2'b00;
      tick();
      chk("ar_restart_req", 32'(imem_req), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller for the pipelined CPU. It drives the program counter's `pc_src` select and write enable, and runs the request/ready handshake with a variable-latency instruction memory. It buffers a fetched instruction across load-use stalls and squashes wrong-path fetches on branch redirects. It sits between the program counter, the instruction memory port, the hazard unit and the IF/ID pipeline register.

## Interface
Parameters:
- `MAX_WAIT`, default 15: number of cycles an outstanding fetch may wait before `timeout_err` sets. Legal range is 1..255.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: load-use stall from the hazard unit; IF/ID and PC must hold.
- `redirect_valid`  in  1: branch resolved taken in ID this cycle.
- `redirect_kind`  in  2: PC source for the redirect. 01 = unconditional, 10 = conditional, 11 = register (BR). 00 is illegal and is ignored.
- `imem_ready`  in  1: `imem_rdata` is valid for the current PC.
- `imem_rdata`  in  32: fetched instruction word.
- `imem_req`  out  1: fetch request. While high, the PC is stable until `imem_ready`.
- `pc_en`  out  1: PC register write enable.
- `pc_src`  out  2: PC mux select. 00 = +4, otherwise the value of `redirect_kind`.
- `if_valid`  out  1: `if_instr` is to be written into IF/ID as a real instruction.
- `if_instr`  out  32: instruction toward IF/ID.
- `if_id_flush`  out  1: write a bubble into IF/ID at this edge.
- `id_hold`  out  1: asks ID to hold its branch operands; a redirect is pending behind an outstanding fetch.
- `timeout_err`  out  1: sticky; a fetch has waited `MAX_WAIT` cycles.

## Operation
A redirect means `redirect_valid`=1 with `redirect_kind`≠00. The state machine has three states: IDLE, FETCH and HOLD.

- **IDLE**: entered on reset. All outputs are 0. Moves unconditionally to FETCH on the first edge after `reset` deasserts.
- **FETCH**: `imem_req`=1. Cases are evaluated in this priority order:
  - `!imem_ready`: wait. `pc_en`=0. The wait counter increments. `id_hold` = redirect. `stall` is ignored.
  - `imem_ready` and redirect: `pc_en`=1, `pc_src`=`redirect_kind`, `if_id_flush`=1, `if_valid`=0 (the fetched word is discarded). Stay in FETCH.
  - `imem_ready` and `stall`: capture `imem_rdata` into the 32-bit buffer. `pc_en`=0. Go to HOLD.
  - `imem_ready` otherwise: `pc_en`=1, `pc_src`=00, `if_valid`=1, `if_instr`=`imem_rdata`. Stay in FETCH.
- **HOLD**: `imem_req`=0 and `if_instr`=buffer.
  - Redirect: discard the buffer. `pc_en`=1, `pc_src`=`redirect_kind`, `if_id_flush`=1. Go to FETCH.
  - `stall` still high: everything is held. `if_valid`=0.
  - `stall` deasserted: `if_valid`=1, `pc_en`=1, `pc_src`=00. Go to FETCH.
- A redirect always beats `stall`. The hazard unit must not assert both for the same instruction, but if it does, the redirect wins.
- **Wait counter**: 8 bits, cleared on every edge where `imem_ready`=1 or the state is not FETCH. Saturates at `MAX_WAIT`. `timeout_err` sets on the edge at which the counter reaches `MAX_WAIT`; only `reset` clears it. The fetch keeps waiting after a timeout.
- **Default values**: outputs not listed for a case are 0, except `if_instr`. In FETCH `if_instr` mirrors `imem_rdata`; in HOLD it mirrors the buffer.

## Timing
- All outputs except `timeout_err` are combinational from the state register and the current inputs. The PC, IF/ID and buffer update at the same rising edge.
- **Reset**:
  - Asserting `reset` mid-fetch immediately forces IDLE and clears the buffer, counter and `timeout_err`.
  - With `reset` asserted, `imem_req`=0, `pc_en`=0, `if_valid`=0, `if_id_flush`=0, `id_hold`=0, `pc_src`=00 and `if_instr`=0.
- **Latency**:
  - Zero-wait memory: one instruction per cycle.
  - N-cycle memory: one instruction per N+1 cycles.
  - The first `imem_req` is one cycle after `reset` falls.
- **Redirect penalty**: exactly one flushed slot when memory is ready. When memory is not ready, the redirect is held via `id_hold` until the `imem_ready` cycle.
- **Address stability**: `pc_en` never pulses while `imem_req`=1 and `imem_ready`=0.

## Structure
- Shared package `cpu_pkg` holds:
  - enum `pc_src_t`: PC_SEQ=00, PC_UNCOND=01, PC_COND=10, PC_REG=11. The program counter's select uses the same encoding.
  - enum `fetch_state_t`: IDLE, FETCH, HOLD.
  - The default value of `MAX_WAIT`.
- No sub-modules. The buffer, counter and FSM are a single module.

## Test plan
- **Reset and streaming**: reset for 2 cycles, then `imem_ready` tied to 1 with words 0x91000421, 0x91000842 → `imem_req` rises 1 cycle after reset falls; `pc_en`=1 and `pc_src`=00 every cycle; `if_valid`=1 with matching `if_instr`.
- **Variable latency**: `imem_ready` low for 3 cycles, then high with 0xAAAA5555 → `pc_en`=0 for 3 cycles, then one cycle of `if_valid`=1, `if_instr`=0xAAAA5555.
- **Stall buffering**: `stall`=1 on the ready cycle of 0x12345678, held for 2 more cycles → HOLD, `imem_req`=0, `pc_en`=0. When `stall` falls, `if_valid`=1 and `if_instr`=0x12345678.
- **Redirect**:
  - With ready: `redirect_kind`=11 → `pc_src`=11, `pc_en`=1, `if_id_flush`=1, `if_valid`=0.
  - Outstanding (ready low 2 cycles): `id_hold`=1 for 2 cycles, then the redirect is applied on the ready cycle.
  - During HOLD: `redirect_kind`=10 → buffer discarded, `pc_src`=10, `if_id_flush`=1.
  - `redirect_kind`=00 with `redirect_valid`=1 → treated as no redirect.
- **Timeout and async reset**:
  - `MAX_WAIT`=4, ready low for 6 cycles → `timeout_err` rises at the 4th wait edge and stays high after ready returns.
  - Asynchronous `reset` mid-wait → outputs clear immediately, without waiting for a clock edge.
